ap_hs_arbiter: RTL and testbench

AP_HS_ARBITER -- requirements
Module: ap_hs_arbiter

---
 rtl/ap_hs_arbiter_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/ap_hs_arbiter.sv | 105 ++++++++++
 tb/tb_ap_hs_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_hs_arbiter_pkg.sv
// ap_hs_arbiter_pkg: shared FSM state type, default widths and clog2 helper
package ap_hs_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TMO_W = 16;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last grant
module rr_arbiter import ap_hs_arbiter_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W = clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);
    logic [ID_W-1:0] c;
    // Scan farthest-first so the nearest requester after last overwrites the rest
    always_comb begin
        gnt = '0;
        idx = '0;
        c = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = ID_W'((int'(last) + k) % NUM_REQ);
            if (req[c]) begin
                gnt = NUM_REQ'(1) << c;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/ap_hs_arbiter.sv
// ap_hs_arbiter: round-robin sharing of one ap_ctrl_hs kernel with watchdog timeout
module ap_hs_arbiter import ap_hs_arbiter_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic                        ACLK_EN,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_arg0,
    input  logic [NUM_REQ*DATA_W-1:0]   req_arg1,
    input  logic [NUM_REQ*DATA_W-1:0]   req_arg2,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    output logic                        ap_start,
    input  logic                        ap_ready,
    input  logic                        ap_done,
    input  logic                        ap_idle,
    input  logic [DATA_W-1:0]           ap_return,
    output logic [DATA_W-1:0]           arg0_o,
    output logic [DATA_W-1:0]           arg1_o,
    output logic [DATA_W-1:0]           arg2_o,
    input  logic [TMO_W-1:0]            tmo_limit,
    output logic                        busy,
    output logic [clog2(NUM_REQ)-1:0]   grant_id
);
    localparam int ID_W = clog2(NUM_REQ);
    state_t state;
    logic [ID_W-1:0] last, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [TMO_W-1:0] wdog, wdog_inc;
    logic tmo_hit, done_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req(req_valid),
        .last(last),
        .gnt(gnt),
        .idx(gnt_idx)
    );

    // The watchdog compares the count including the current cycle, so a limit of L
    // ends the job L cycles after START entry; done in START only counts alongside ready
    always_comb begin
        wdog_inc = (&wdog) ? wdog : wdog + 1'b1;
        tmo_hit = (tmo_limit != '0) && (wdog_inc == tmo_limit);
        done_hit = ap_done && (state == RUN || ap_ready);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
            ap_start <= 1'b0;
            busy <= 1'b0;
            arg0_o <= '0;
            arg1_o <= '0;
            arg2_o <= '0;
            grant_id <= '0;
            last <= ID_W'(NUM_REQ - 1);
            wdog <= '0;
        end else if (ACLK_EN) begin
            req_ready <= '0;
            case (state)
                IDLE: if (ap_idle && |req_valid) begin
                    state <= START;
                    req_ready <= gnt;
                    grant_id <= gnt_idx;
                    last <= gnt_idx;
                    arg0_o <= req_arg0[gnt_idx*DATA_W +: DATA_W];
                    arg1_o <= req_arg1[gnt_idx*DATA_W +: DATA_W];
                    arg2_o <= req_arg2[gnt_idx*DATA_W +: DATA_W];
                    ap_start <= 1'b1;
                    busy <= 1'b1;
                    wdog <= '0;
                end
                START, RUN: begin
                    wdog <= wdog_inc;
                    if (done_hit || tmo_hit) begin
                        state <= RESP;
                        ap_start <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                        rsp_data <= done_hit ? ap_return : '0;
                        rsp_err <= !done_hit;
                    end else if (state == START && ap_ready) begin
                        state <= RUN;
                        ap_start <= 1'b0;
                    end
                end
                RESP: if (rsp_ready[grant_id]) begin
                    state <= IDLE;
                    rsp_valid <= '0;
                    rsp_err <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ap_hs_arbiter.sv
// tb_ap_hs_arbiter: directed jobs checked per cycle against a phase-level reference model
module tb_ap_hs_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int T = 16;

    logic ACLK = 1'b0;
    logic ARESETN, ACLK_EN;
    logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_arg0, req_arg1, req_arg2;
    logic [W-1:0] rsp_data, ap_return, arg0_o, arg1_o, arg2_o;
    logic rsp_err, ap_start, ap_ready, ap_done, ap_idle, busy;
    logic [T-1:0] tmo_limit;
    logic [1:0] grant_id;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int g_cyc = 0;
    int run_cnt = 0;

    ap_hs_arbiter #(.NUM_REQ(N), .DATA_W(W), .TMO_W(T)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .ACLK_EN(ACLK_EN),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_arg0(req_arg0), .req_arg1(req_arg1), .req_arg2(req_arg2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .ap_return(ap_return), .arg0_o(arg0_o), .arg1_o(arg1_o), .arg2_o(arg2_o),
        .tmo_limit(tmo_limit), .busy(busy), .grant_id(grant_id)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;
    // A busy cycle with neither ap_start nor a response pending can only be RUN
    always @(negedge ACLK) if (busy && !ap_start && rsp_valid == '0) run_cnt <= run_cnt + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int from);
        for (int k = 1; k <= N; k++) if (v[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    // Reference model: 0 idle, 1 start, 2 run, 3 resp; m_el counts enabled job cycles
    int m_phase, m_gid, m_last, m_el, m_pick;
    logic [W-1:0] m_a0, m_a1, m_a2, m_data;
    logic m_err;
    logic [N-1:0] m_ack;
    always_comb m_pick = rr_pick(req_valid, m_last);

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_phase <= 0; m_gid <= 0; m_last <= N - 1; m_el <= 0;
            m_a0 <= '0; m_a1 <= '0; m_a2 <= '0; m_data <= '0; m_err <= 1'b0; m_ack <= '0;
        end else if (ACLK_EN) begin
            m_ack <= '0;
            case (m_phase)
                0: if (ap_idle && m_pick >= 0) begin
                    m_phase <= 1; m_gid <= m_pick; m_last <= m_pick; m_el <= 0;
                    m_ack <= 4'b0001 << m_pick;
                    m_a0 <= req_arg0[m_pick*W +: W];
                    m_a1 <= req_arg1[m_pick*W +: W];
                    m_a2 <= req_arg2[m_pick*W +: W];
                end
                1, 2: begin
                    m_el <= m_el + 1;
                    if (ap_done && (m_phase == 2 || ap_ready)) begin
                        m_phase <= 3; m_data <= ap_return; m_err <= 1'b0;
                    end else if (tmo_limit != 0 && m_el + 1 == int'(tmo_limit)) begin
                        m_phase <= 3; m_data <= '0; m_err <= 1'b1;
                    end else if (m_phase == 1 && ap_ready) m_phase <= 2;
                end
                default: if (rsp_ready[m_gid]) begin
                    m_phase <= 0; m_err <= 1'b0;
                end
            endcase
        end
    end

    always @(negedge ACLK) begin
        check("busy", busy, m_phase != 0);
        check("ap_start", ap_start, m_phase == 1);
        check("rsp_valid", rsp_valid, (m_phase == 3) ? (4'b0001 << m_gid) : 4'b0000);
        check("req_ready", req_ready, m_ack);
        check("grant_id", grant_id, m_gid);
        check("rsp_data", rsp_data, m_data);
        check("rsp_err", rsp_err, m_err);
        check("arg0_o", arg0_o, m_a0);
        check("arg1_o", arg1_o, m_a1);
        check("arg2_o", arg2_o, m_a2);
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic request(input int r, input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2);
        req_valid[r] = 1'b1;
        req_arg0[r*W +: W] = a0;
        req_arg1[r*W +: W] = a1;
        req_arg2[r*W +: W] = a2;
        for (int i = 0; i < 50 && !req_ready[r]; i++) tick();
        check("req_ready_seen", req_ready[r], 1'b1);
        g_cyc = cyc;
        req_valid[r] = 1'b0;
    endtask

    task automatic kernel(input int rdy_dly, input bit same, input int done_dly, input logic [W-1:0] ret, input bit do_done);
        repeat (rdy_dly) tick();
        ap_ready = 1'b1;
        ap_done = same;
        ap_return = ret;
        tick();
        ap_ready = 1'b0;
        ap_done = 1'b0;
        if (!same && do_done) begin
            repeat (done_dly) tick();
            ap_done = 1'b1;
            ap_return = ret;
            tick();
            ap_done = 1'b0;
        end
    endtask

    task automatic respond(input int r, input int bp, output int lat, output logic [W-1:0] d, output logic e, output logic [N-1:0] v);
        logic stable;
        for (int i = 0; i < 200 && !rsp_valid[r]; i++) tick();
        check("rsp_valid_seen", rsp_valid[r], 1'b1);
        lat = cyc - g_cyc;
        d = rsp_data;
        e = rsp_err;
        v = rsp_valid;
        stable = 1'b1;
        if (bp > 0) rsp_ready = ~(4'b0001 << r);
        for (int i = 0; i < bp; i++) begin
            ap_done = (i == 5);
            ap_return = 32'hDEAD;
            tick();
            stable &= (rsp_valid == v) && (rsp_data == d) && (rsp_err == e);
        end
        ap_done = 1'b0;
        if (bp > 0) check("bp_stable", stable, 1'b1);
        rsp_ready = 4'b0001 << r;
        tick();
        rsp_ready = '0;
    endtask

    int lat, rc;
    logic [W-1:0] d;
    logic e, ok;
    logic [N-1:0] v;
    int seq[8];
    int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        ARESETN = 1'b0; ACLK_EN = 1'b1; req_valid = '0; rsp_ready = '0;
        req_arg0 = '0; req_arg1 = '0; req_arg2 = '0;
        ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1; ap_return = '0; tmo_limit = '0;
        repeat (2) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_ap_start", ap_start, 1'b0);
        check("rst_rsp_valid", rsp_valid, 4'b0000);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_arg0", arg0_o, 32'h0);
        ARESETN = 1'b1;

        for (int i = 0; i < N; i++) begin
            req_arg0[i*W +: W] = 32'h100 + i;
            req_arg1[i*W +: W] = 32'h200 + i;
            req_arg2[i*W +: W] = 32'h300 + i;
        end
        req_valid = 4'hF;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 50 && req_ready == '0; i++) tick();
            check("fair_grant_seen", |req_ready, 1'b1);
            seq[j] = int'(grant_id);
            kernel(0, 1'b1, 0, 32'(j), 1'b1);
            respond(int'(grant_id), 0, lat, d, e, v);
            check("fair_rsp_data", d, 32'(j));
        end
        req_valid = '0;
        for (int j = 0; j < 8; j++) check("fair_seq", seq[j], exp_seq[j]);

        request(2, 32'h11, 32'h22, 32'h33);
        check("single_grant", grant_id, 2'd2);
        kernel(2, 1'b0, 5, 32'hCAFE, 1'b1);
        respond(2, 0, lat, d, e, v);
        check("single_valid", v, 4'b0100);
        check("single_data", d, 32'hCAFE);
        check("single_err", e, 1'b0);
        check("single_arg0", arg0_o, 32'h11);
        check("single_arg1", arg1_o, 32'h22);
        check("single_arg2", arg2_o, 32'h33);

        tmo_limit = 16'd10;
        request(1, 32'hA0, 32'hA1, 32'hA2);
        kernel(0, 1'b0, 0, 32'h0, 1'b0);
        respond(1, 0, lat, d, e, v);
        check("tmo_latency", lat, 10);
        check("tmo_err", e, 1'b1);
        check("tmo_data", d, 32'h0);
        request(1, 32'hB0, 32'hB1, 32'hB2);
        kernel(1, 1'b0, 3, 32'h1234, 1'b1);
        respond(1, 0, lat, d, e, v);
        check("after_tmo_err", e, 1'b0);
        check("after_tmo_data", d, 32'h1234);
        request(3, 32'hC0, 32'hC1, 32'hC2);
        kernel(0, 1'b0, 8, 32'h77, 1'b1);
        respond(3, 0, lat, d, e, v);
        check("done_at_limit_lat", lat, 10);
        check("done_at_limit_err", e, 1'b0);
        check("done_at_limit_data", d, 32'h77);

        request(1, 32'hD0, 32'hD1, 32'hD2);
        tick();
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        ACLK_EN = 1'b0;
        repeat (5) tick();
        check("frozen_in_run", {busy, ap_start}, 2'b10);
        ACLK_EN = 1'b1;
        respond(1, 0, lat, d, e, v);
        check("frozen_tmo_latency", lat, 15);
        check("frozen_tmo_err", e, 1'b1);

        tmo_limit = '0;
        rc = run_cnt;
        request(3, 32'hE0, 32'hE1, 32'hE2);
        kernel(1, 1'b1, 0, 32'h5, 1'b1);
        respond(3, 0, lat, d, e, v);
        check("same_cycle_data", d, 32'h5);
        check("same_cycle_no_run", run_cnt - rc, 0);

        request(0, 32'hF0, 32'hF1, 32'hF2);
        kernel(0, 1'b0, 2, 32'hBEEF, 1'b1);
        respond(0, 20, lat, d, e, v);
        check("bp_data", d, 32'hBEEF);

        ap_return = 32'hBAD;
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        tick();
        check("idle_done_busy", busy, 1'b0);
        check("idle_done_data", rsp_data, 32'hBEEF);

        ap_idle = 1'b0;
        req_valid[0] = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            tick();
            ok &= (req_ready == '0) && !busy;
        end
        check("ap_idle_low_no_grant", ok, 1'b1);
        ap_idle = 1'b1;
        request(0, 32'h1, 32'h2, 32'h3);
        check("ap_idle_grant", grant_id, 2'd0);
        kernel(0, 1'b1, 0, 32'h42, 1'b1);
        respond(0, 0, lat, d, e, v);
        check("ap_idle_data", d, 32'h42);

        ap_idle = 1'b0;
        req_valid[2] = 1'b1;
        repeat (2) tick();
        req_valid[2] = 1'b0;
        ap_idle = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            tick();
            ok &= !busy && (req_ready == '0);
        end
        check("dropped_req_not_granted", ok, 1'b1);

        request(2, 32'h9, 32'h8, 32'h7);
        tick();
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        tick();
        check("pre_reset_run", {busy, ap_start}, 2'b10);
        #2;
        ARESETN = 1'b0;
        #1;
        check("async_rst_ap_start", ap_start, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        repeat (2) tick();
        ARESETN = 1'b1;
        ap_done = 1'b1;
        ap_return = 32'h99;
        ok = 1'b1;
        repeat (8) begin
            tick();
            ap_done = 1'b0;
            ok &= (rsp_valid == '0) && !busy;
        end
        check("no_rsp_after_reset", ok, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
